// File: rtl/nand_chain_pipe.sv
// Pipelined NAND cascade with one NAND level per register stage and a global stall.
// Define NAND_CHAIN_CNT_EN to add the 16-bit output-transfer counter port CNT.
module nand_chain_pipe #(
    parameter int WIDTH = 8,
    parameter int NOPS  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NOPS*WIDTH-1:0]   OPS,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        D,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef NAND_CHAIN_CNT_EN
    ,
    output logic [15:0]             CNT
`endif
);

    logic adv;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Stage s holds r(s+1) plus the operands still waiting for later stages.
    for (genvar s = 0; s < NOPS - 1; s++) begin : g_stg
        logic             vld_d, vld_q, vld_in;
        logic [WIDTH-1:0] res_d, res_q, res_in;

        if (s == 0) begin : g_src
            assign vld_in = in_valid;
            assign res_in = ~(OPS[0 +: WIDTH] & OPS[WIDTH +: WIDTH]);
        end else begin : g_src
            assign vld_in = g_stg[s-1].vld_q;
            assign res_in = ~(g_stg[s-1].res_q & g_stg[s-1].g_rem.rem_q[WIDTH-1:0]);
        end

        always_comb begin
            vld_d = vld_q;
            res_d = res_q;
            if (adv) begin
                vld_d = vld_in;
                if (vld_in) begin
                    res_d = res_in;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                res_q <= '0;
            end else begin
                vld_q <= vld_d;
                res_q <= res_d;
            end
        end

        if (s < NOPS - 2) begin : g_rem
            localparam int RW = (NOPS - 2 - s) * WIDTH;
            logic [RW-1:0] rem_d, rem_q, rem_in;

            // Lowest remaining operand is consumed by the next stage; the rest moves along.
            if (s == 0) begin : g_ri
                assign rem_in = OPS[NOPS*WIDTH-1 : 2*WIDTH];
            end else begin : g_ri
                assign rem_in = g_stg[s-1].g_rem.rem_q[RW+WIDTH-1 : WIDTH];
            end

            always_comb begin
                rem_d = rem_q;
                if (adv && vld_in) begin
                    rem_d = rem_in;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rem_q <= '0;
                end else begin
                    rem_q <= rem_d;
                end
            end
        end
    end

    assign out_valid = g_stg[NOPS-2].vld_q;
    assign D         = g_stg[NOPS-2].res_q;

`ifdef NAND_CHAIN_CNT_EN
    logic [15:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CNT = cnt_q;
`endif

endmodule

// File: tb/tb_nand_chain_pipe.sv
// Directed bench for nand_chain_pipe: NOPS=3/WIDTH=8 main instance, NOPS=2/WIDTH=4 side instance.
module tb_nand_chain_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] ops;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  d;

    logic [7:0]  ops2;
    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [3:0]  d2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

`ifdef NAND_CHAIN_CNT_EN
    logic [15:0] cnt;
`endif

    nand_chain_pipe #(.WIDTH(8), .NOPS(3)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .OPS       (ops),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (d),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef NAND_CHAIN_CNT_EN
        ,
        .CNT       (cnt)
`endif
    );

    nand_chain_pipe #(.WIDTH(4), .NOPS(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .OPS       (ops2),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .D         (d2),
        .out_valid (out_valid2),
        .out_ready (out_ready2)
`ifdef NAND_CHAIN_CNT_EN
        ,
        .CNT       ()
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        rst        = 1'b1;
        ops        = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        ops2       = '0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_d", 64'(d), 64'h00);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid2", 64'(out_valid2), 64'd0);
        rst = 1'b0;

        // Single transfer, latency 2; NOPS=2 instance latency 1
        out_ready = 1'b1;
        ops       = {8'hAA, 8'hCC, 8'hF0};
        in_valid  = 1'b1;
        ops2      = {4'h3, 4'h5};
        in_valid2 = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        ops       = 24'h123456;
        ops2      = 8'hFF;
        check("lat_cyc1_valid", 64'(out_valid), 64'd0);
        check("n2_valid", 64'(out_valid2), 64'd1);
        check("n2_d", 64'(d2), 64'hE);
        tick();
        check("lat_cyc2_valid", 64'(out_valid), 64'd1);
        check("lat_cyc2_d", 64'(d), 64'hD5);
        check("n2_bubble", 64'(out_valid2), 64'd0);
        tick();
        check("lat_bubble", 64'(out_valid), 64'd0);

        // Back-to-back all-ones then all-zeros
        ops      = 24'hFFFFFF;
        in_valid = 1'b1;
        tick();
        check("b2b_in_ready0", 64'(in_ready), 64'd1);
        ops = 24'h000000;
        tick();
        check("b2b_in_ready1", 64'(in_ready), 64'd1);
        check("b2b_valid0", 64'(out_valid), 64'd1);
        check("b2b_d0", 64'(d), 64'hFF);
        in_valid = 1'b0;
        tick();
        check("b2b_valid1", 64'(out_valid), 64'd1);
        check("b2b_d1", 64'(d), 64'hFF);
        tick();
        check("b2b_drain", 64'(out_valid), 64'd0);

        // Back-pressure: two results queued, five stalled cycles with garbage offered
        out_ready = 1'b0;
        ops       = {8'h0F, 8'h33, 8'h55};
        in_valid  = 1'b1;
        tick();
        ops = {8'h3C, 8'h81, 8'hC3};
        tick();
        check("stall_in_ready", 64'(in_ready), 64'd0);
        ops = 24'h00A5FF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_d", 64'(d), 64'hF1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            ops = ops + 24'h010203;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("release_next_valid", 64'(out_valid), 64'd1);
        check("release_next_d", 64'(d), 64'hC3);
        tick();
        check("release_no_dup", 64'(out_valid), 64'd0);

        // Reset one cycle after a transfer discards it
        ops      = {8'hAA, 8'hCC, 8'hF0};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_d", 64'(d), 64'h00);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("mid_rst_valid_a", 64'(out_valid), 64'd0);
        tick();
        check("mid_rst_valid_b", 64'(out_valid), 64'd0);

`ifdef NAND_CHAIN_CNT_EN
        // 65537 output transfers wrap the counter to 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("cnt_rst", 64'(cnt), 64'h0);
        ops      = '0;
        in_valid = 1'b1;
        for (int i = 0; i < 65537; i++) tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("cnt_wrap", 64'(cnt), 64'h0001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nand_chain_pipe.md
NAND_CHAIN_PIPE -- requirements
Module: nand_chain_pipe

Interface
REQ-001 Parameter WIDTH, default 8, sets the bit width of each operand and of the result; legal range 1..64.
REQ-002 Parameter NOPS, default 3, sets the number of operands in the NAND cascade; legal range 2..16.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 OPS  input  NOPS*WIDTH  packed operands; operand k occupies bits [k*WIDTH +: WIDTH], k=0..NOPS-1.
REQ-006 in_valid  input  1  OPS holds a valid operand set this cycle.
REQ-007 in_ready  output  1  the block accepts OPS this cycle.
REQ-008 D  output  WIDTH  cascade result.
REQ-009 out_valid  output  1  D holds a valid result.
REQ-010 out_ready  input  1  the sink accepts D this cycle.

Function
REQ-011 The result SHALL be: r1 = ~(op0 & op1); rk = ~(r(k-1) & opk) for k=2..NOPS-1; D = r(NOPS-1).
- All operations are bitwise over WIDTH bits.
- No width extension or truncation.
REQ-012 The pipeline SHALL have NOPS-1 register stages, one NAND level per stage.
- Each stage holds a valid bit, its partial result, and the not-yet-consumed operands.
REQ-013 The global advance signal adv SHALL equal (~out_valid | out_ready).
- When adv=1, every stage loads from its predecessor.
- When adv=0, every stage holds.
REQ-014 in_ready SHALL equal adv, combinationally.
- An input transfer occurs on (in_valid & in_ready).
REQ-015 When adv=1, stage 1's valid bit SHALL load in_valid, so a bubble enters when in_valid=0.
REQ-016 Latency SHALL be exactly NOPS-1 cycles from input transfer to out_valid=1, with out_ready held at 1.
REQ-017 Throughput SHALL be one result per cycle while in_valid=1 and out_ready=1.
REQ-018 While out_valid=1 and out_ready=0, D and out_valid SHALL remain stable, and no input is accepted.
REQ-019 Simultaneous output transfer and input transfer in the same cycle SHALL both take effect; no data loss and no duplication.
REQ-020 For NOPS=2, the block SHALL be a single registered NAND stage with latency 1.
REQ-021 OPS SHALL be ignored whenever in_valid=0 or in_ready=0.

Reset
REQ-022 While rst=1 at a rising edge, all stage valid bits, partial results and stored operands SHALL clear to 0.
- Resulting outputs: out_valid=0, D=0.
REQ-023 Reset mid-operation SHALL discard all in-flight results; no result from before reset appears afterwards.
REQ-024 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-025 With macro NAND_CHAIN_CNT_EN defined, the block SHALL add output port CNT (16 bits).
- CNT counts output transfers (out_valid & out_ready).
- CNT resets to 0 and wraps from 0xFFFF to 0x0000.
REQ-026 Without NAND_CHAIN_CNT_EN, port CNT and its logic SHALL be absent, and all other behaviour is identical.

Verification (WIDTH=8, NOPS=3 unless stated)
REQ-027 OPS={C=0xAA,B=0xCC,A=0xF0}, in_valid=1 for 1 cycle, out_ready=1 -> out_valid=1 exactly 2 cycles later with D=0xD5.
REQ-028 OPS all 0xFF, then all 0x00, back-to-back, out_ready=1 -> D=0xFF, then D=0xFF, on consecutive cycles; in_ready stays 1.
REQ-029 Result pending with out_ready=0 for 5 cycles -> D and out_valid stable, in_ready=0; on out_ready=1, the transfer occurs and the next queued result follows with no loss.
REQ-030 rst=1 asserted one cycle after an input transfer -> out_valid never rises for that input; after release, out_valid=0, D=0x00, in_ready=1.
REQ-031 NOPS=2, WIDTH=4, OPS={0x3,0x5} -> D=0xE, out_valid 1 cycle after the transfer.
REQ-032 With NAND_CHAIN_CNT_EN, 65537 output transfers -> CNT=0x0001; with the macro absent, the build has no CNT port.
